// File: rtl/matrix_pkg.sv
// Shared constants and helpers for the LED-matrix receive-side capture model.
package matrix_pkg;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int ROW_W = $clog2(ROWS);

  // Result of a one-hot decode: index of the set bit plus a flag that
  // exactly one bit was set.
  typedef struct packed {
    logic             valid;
    logic [ROW_W-1:0] idx;
  } onehot_t;

  // Decode a row-select vector; idx is meaningful only when valid is set.
  function automatic onehot_t onehot_idx(input logic [ROWS-1:0] v);
    onehot_t r;
    int      cnt;
    r   = '0;
    cnt = 0;
    for (int i = 0; i < ROWS; i++) begin
      if (v[i]) begin
        cnt   = cnt + 1;
        r.idx = ROW_W'(i);
      end
    end
    r.valid = (cnt == 1);
    return r;
  endfunction

endpackage

// File: rtl/matrix_capture_pin_sync.sv
// Two-flop synchronizer for one asynchronous matrix pin, with a previous-value
// flop so a single-cycle rising-edge strobe can be derived on the clk side.
module pin_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic s,
  output logic rise
);

  logic meta;
  logic prev;

  // Synchronizer chain plus one-cycle-delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      s    <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= pin;
      s    <= meta;
      prev <= s;
    end
  end

  assign rise = s & ~prev;

endmodule

// File: rtl/matrix_capture.sv
// Receive-side model of the LED-matrix serial interface: rebuilds the frame
// driven onto the six matrix pins into a row-indexed store and flags latches
// whose row selection is not one-hot.
module matrix_capture
  import matrix_pkg::*;
#(
  parameter int ROWS = matrix_pkg::ROWS,
  parameter int COLS = matrix_pkg::COLS
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    rclk,
  input  logic                    rsdi,
  input  logic                    cclk,
  input  logic                    csdi,
  input  logic                    le,
  input  logic                    oeb,
  input  logic [$clog2(ROWS)-1:0] rd_row,
  output logic [COLS-1:0]         rd_data,
  output logic [COLS-1:0]         lit,
  output logic [$clog2(ROWS)-1:0] lit_row,
  output logic                    frame_done,
  output logic                    row_err,
  output logic [15:0]             latch_cnt
);

  localparam int NPINS = 6;

  // Pin order in the synchronizer bank: clocks first so their rise strobes
  // occupy the low bits; data and oeb rise strobes are never used.
  logic [NPINS-1:0] pins;
  logic [NPINS-1:0] pins_s;
  logic [NPINS-1:0] pins_rise;

  assign pins = {oeb, csdi, rsdi, le, cclk, rclk};

  genvar gi;
  generate
    for (gi = 0; gi < NPINS; gi++) begin : g_sync
      pin_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .pin     (pins[gi]),
        .s       (pins_s[gi]),
        .rise    (pins_rise[gi])
      );
    end
  endgenerate

  logic rclk_rise, cclk_rise, le_rise;
  logic rsdi_s, csdi_s, oeb_s;
  logic unused_rise;

  assign rclk_rise   = pins_rise[0];
  assign cclk_rise   = pins_rise[1];
  assign le_rise     = pins_rise[2];
  assign rsdi_s      = pins_s[3];
  assign csdi_s      = pins_s[4];
  assign oeb_s       = pins_s[5];
  assign unused_rise = ^{pins_rise[5:3], pins_s[2:0]};

  logic [COLS-1:0] col_sr;
  logic [ROWS-1:0] row_sr;
  logic [COLS-1:0] col_q;
  logic [ROWS-1:0] row_q;
  logic [ROWS-1:0] written;
  logic [ROWS-1:0] written_set;
  logic            all_written;
  logic [COLS-1:0] frame [ROWS];

  onehot_t row_oh;
  onehot_t q_oh;
  logic    wr_en;

  assign row_oh = onehot_idx(row_sr);
  assign q_oh   = onehot_idx(row_q);
  assign wr_en  = le_rise & row_oh.valid;

  // Row coverage including the write committing this cycle; a full set
  // produces frame_done and restarts tracking in the same cycle.
  always_comb begin
    written_set = written;
    if (wr_en) begin
      written_set[row_oh.idx] = 1'b1;
    end
    all_written = &written_set;
  end

  // Shift chains; a latch in the same cycle sees the pre-shift values
  // because both updates are non-blocking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_sr <= '0;
      row_sr <= '0;
    end else begin
      if (cclk_rise) col_sr <= {col_sr[COLS-2:0], csdi_s};
      if (rclk_rise) row_sr <= {row_sr[ROWS-2:0], rsdi_s};
    end
  end

  // Output latches, latch counter, sticky row error and frame completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q      <= '0;
      row_q      <= '0;
      latch_cnt  <= '0;
      row_err    <= 1'b0;
      written    <= '0;
      frame_done <= 1'b0;
    end else begin
      if (le_rise) begin
        col_q     <= col_sr;
        row_q     <= row_sr;
        latch_cnt <= latch_cnt + 16'd1;
        if (!row_oh.valid) row_err <= 1'b1;
      end
      written    <= all_written ? '0 : written_set;
      frame_done <= all_written;
    end
  end

  // Frame store: one flop row per matrix row, cleared on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < ROWS; r++) frame[r] <= '0;
    end else if (wr_en) begin
      frame[row_oh.idx] <= col_sr;
    end
  end

  // Registered read port; a same-cycle write is seen on the next read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= frame[rd_row];
    end
  end

  assign lit     = oeb_s ? '0 : col_q;
  assign lit_row = q_oh.valid ? q_oh.idx : '0;

endmodule

// File: tb/tb_matrix_capture.sv
// Randomized scoreboard bench for matrix_capture: the stimulus process drives
// the pins, updates a behavioural model and queues expected frame_done and
// read responses; a monitor pops and compares when the DUT presents them.
module tb_matrix_capture;

  localparam int ROWS = 8;
  localparam int COLS = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rclk = 1'b0, rsdi = 1'b0, cclk = 1'b0, csdi = 1'b0, le = 1'b0;
  logic       oeb = 1'b1;
  logic [2:0] rd_row = 3'd0;
  logic [7:0] rd_data, lit;
  logic [2:0] lit_row;
  logic       frame_done, row_err;
  logic [15:0] latch_cnt;

  matrix_capture #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rclk       (rclk),
    .rsdi       (rsdi),
    .cclk       (cclk),
    .csdi       (csdi),
    .le         (le),
    .oeb        (oeb),
    .rd_row     (rd_row),
    .rd_data    (rd_data),
    .lit        (lit),
    .lit_row    (lit_row),
    .frame_done (frame_done),
    .row_err    (row_err),
    .latch_cnt  (latch_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model of what the pins have described so far.
  bit [7:0] m_col_sr, m_row_sr, m_col_q, m_row_q;
  bit [7:0] m_frame [8];
  bit [7:0] m_written;
  int       m_latches;
  bit       m_err;

  int       done_q[$];
  bit [7:0] rd_q[$];
  logic     rd_req  = 1'b0;
  logic     rd_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit is_onehot(input bit [7:0] v);
    return $countones(v) == 1;
  endfunction

  function automatic int bit_pos(input bit [7:0] v);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) if (v[i]) p = i;
    return p;
  endfunction

  function automatic void model_reset();
    m_col_sr = '0; m_row_sr = '0; m_col_q = '0; m_row_q = '0;
    for (int i = 0; i < 8; i++) m_frame[i] = '0;
    m_written = '0; m_latches = 0; m_err = 1'b0;
  endfunction

  // Effect of one latch-enable edge on the model; uses pre-shift registers.
  function automatic void model_latch(input int edge_cyc);
    int idx;
    m_col_q = m_col_sr;
    m_row_q = m_row_sr;
    m_latches++;
    if (is_onehot(m_row_sr)) begin
      idx = bit_pos(m_row_sr);
      m_frame[idx]   = m_col_sr;
      m_written[idx] = 1'b1;
      if (m_written == 8'hFF) begin
        done_q.push_back(edge_cyc + 3);
        m_written = '0;
      end
    end else begin
      m_err = 1'b1;
    end
  endfunction

  task automatic check_status();
    bit [2:0] exp_row;
    exp_row = is_onehot(m_row_q) ? 3'(bit_pos(m_row_q)) : 3'd0;
    check("latch_cnt", 32'(latch_cnt), 32'(m_latches & 16'hFFFF));
    check("row_err",   32'(row_err),   32'(m_err));
    check("lit_row",   32'(lit_row),   32'(exp_row));
    check("lit",       32'(lit),       oeb ? 32'd0 : 32'(m_col_q));
  endtask

  task automatic shift_col(input bit b);
    csdi = b; tick(4);
    cclk = 1'b1; m_col_sr = {m_col_sr[6:0], b}; tick(4);
    cclk = 1'b0; tick(4);
  endtask

  task automatic shift_row(input bit b);
    rsdi = b; tick(4);
    rclk = 1'b1; m_row_sr = {m_row_sr[6:0], b}; tick(4);
    rclk = 1'b0; tick(4);
  endtask

  // Shift a full column pattern and row pattern, most significant bit first.
  task automatic load(input bit [7:0] col, input bit [7:0] row);
    for (int i = 7; i >= 0; i--) shift_col(col[i]);
    for (int i = 7; i >= 0; i--) shift_row(row[i]);
  endtask

  task automatic do_latch();
    le = 1'b1; model_latch(cyc); tick(4);
    le = 1'b0; tick(4);
    check_status();
  endtask

  task automatic read_row(input int r);
    rd_row = 3'(r); rd_req = 1'b1; rd_q.push_back(m_frame[r]);
    tick(1);
    rd_req = 1'b0; tick(1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    tick(2);
    check("rst_rd_data",    32'(rd_data),    32'd0);
    check("rst_lit",        32'(lit),        32'd0);
    check("rst_lit_row",    32'(lit_row),    32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_row_err",    32'(row_err),    32'd0);
    check("rst_latch_cnt",  32'(latch_cnt),  32'd0);
    reset_n = 1'b1;
    tick(2);
  endtask

  // Monitor: compare frame_done pulses and registered reads against queues.
  always @(posedge clk) rd_seen <= rd_req;

  always @(negedge clk) begin
    if (reset_n) begin
      if (frame_done) begin
        if (done_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL frame_done_unexpected: pulse at cycle %0d, none expected", cyc);
        end else begin
          check("frame_done_cycle", 32'(cyc), 32'(done_q.pop_front()));
        end
      end
      if (rd_seen) begin
        if (rd_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rd_queue_empty: rd_data %0h with no expected value", rd_data);
        end else begin
          check("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d checks, required completion", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit [7:0] c, r;
    tick(1);
    do_reset();

    // Single row write with the reference pattern.
    load(8'b10110001, 8'b00000100);
    do_latch();
    read_row(2);

    // One latch per row; the eighth completes the frame.
    for (int i = 0; i < 8; i++) begin
      load(8'h01 << i, 8'h01 << i);
      do_latch();
    end
    read_row(5);

    // Non-one-hot row select: no write, sticky error.
    load(8'h55, 8'b00000110);
    do_latch();
    read_row(1);
    load(8'hAA, 8'h08);
    do_latch();
    read_row(3);

    // Output enable gating of lit.
    load(8'hF0, 8'h10);
    do_latch();
    oeb = 1'b0;
    tick(2);
    check("lit_after_oeb", 32'(lit), 32'h0F0);

    // Column clock and latch enable on the same edge.
    csdi = 1'b1; tick(4);
    cclk = 1'b1; le = 1'b1;
    model_latch(cyc);
    m_col_sr = {m_col_sr[6:0], 1'b1};
    tick(4);
    cclk = 1'b0; le = 1'b0; tick(4);
    check_status();
    do_latch();

    // Randomized frames, occasionally with a malformed row select.
    for (int k = 0; k < 6; k++) begin
      c = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r = 8'($urandom);
      else r = 8'h01 << $urandom_range(0, 7);
      load(c, r);
      do_latch();
      read_row(int'($urandom_range(0, 7)));
    end

    // Reset in the middle of a frame, then a full frame afterwards.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      load(8'h80 >> i, 8'h01 << i);
      do_latch();
    end
    do_reset();
    read_row(3);
    for (int i = 0; i < 8; i++) begin
      load(8'(8'h11 + i), 8'h01 << i);
      do_latch();
    end
    read_row(7);
    tick(4);

    check("done_q_drained", 32'(done_q.size()), 32'd0);
    check("rd_q_drained",   32'(rd_q.size()),   32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
